// File: rtl/intv_bank_writer.sv
// Load-side writer for the even/odd interval ping memory: packs valid intervals
// into alternating banks and publishes the stream length and a done flag.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif

package intv_bank_writer_pkg;
  typedef struct packed {
    logic signed [63:0] first;
    logic signed [63:0] second;
  } tuple_pair_t;
endpackage

module intv_bank_writer
  import intv_bank_writer_pkg::*;
#(
  parameter int MAX_INTV = (1 << `BANK_ADDR_WIDTH) - 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_in,
  input  logic                        intv_valid_in,
  input  tuple_pair_t                 intv_in,
  input  logic                        intv_last_in,
  output logic                        intv_ready_out,
  output logic                        even_wr_en_out,
  output logic                        odd_wr_en_out,
  output logic [`BANK_ADDR_WIDTH-1:0] wr_addr_out,
  output tuple_pair_t                 wr_data_out,
  output logic [31:0]                 stream_len_out,
  output logic                        load_done_out,
  output logic                        overflow_out,
  output logic [31:0]                 bad_intv_count_out
);

  localparam int AW = `BANK_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_count;
  logic [31:0]   r_bad_count;
  logic          r_overflow;
  logic          r_done;
  logic          r_even_wr;
  logic          r_odd_wr;
  logic [AW-1:0] r_addr;
  tuple_pair_t   r_data;

  logic w_ready;
  logic w_accept;
  logic w_bad;
  logic w_full;

  assign w_ready  = (r_state == LOAD);
  assign w_accept = w_ready && intv_valid_in;
  assign w_bad    = (intv_in.first > intv_in.second);
  assign w_full   = (r_count == 32'(MAX_INTV));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start_in) w_state_nxt = LOAD;
      LOAD: begin
        if (start_in)                        w_state_nxt = LOAD;
        else if (w_accept && intv_last_in)   w_state_nxt = DONE;
      end
      DONE: if (start_in) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // start_in wins over a same-cycle beat, so a restart discards it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_bad_count <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_even_wr   <= 1'b0;
      r_odd_wr    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_even_wr <= 1'b0;
      r_odd_wr  <= 1'b0;
      r_done    <= (r_state == DONE) && !start_in;
      if (start_in) begin
        r_count     <= '0;
        r_bad_count <= '0;
        r_overflow  <= 1'b0;
      end else if (w_accept) begin
        if (w_bad) begin
          r_bad_count <= r_bad_count + 32'd1;
        end else if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_even_wr <= ~r_count[0];
          r_odd_wr  <= r_count[0];
          r_addr    <= r_count[AW-1:0];
          r_data    <= intv_in;
          r_count   <= r_count + 32'd1;
        end
      end
    end
  end

  // Strobes are masked by reset so a write queued before reset never lands.
  assign intv_ready_out     = w_ready;
  assign even_wr_en_out     = r_even_wr && !reset;
  assign odd_wr_en_out      = r_odd_wr && !reset;
  assign wr_addr_out        = r_addr;
  assign wr_data_out        = r_data;
  assign stream_len_out     = r_count;
  assign load_done_out      = r_done;
  assign overflow_out       = r_overflow;
  assign bad_intv_count_out = r_bad_count;

endmodule
